// File: rtl/mgr_noc_cp_arb.sv
// ----------------------------------------------------------------------------
// mgr_noc_cp_arb
//   Packet-level round-robin arbiter that shares the manager's single NoC
//   control-path output between NUM_REQ upstream requesters (by default the
//   return data processor and the return control processor). A grant is held
//   for a whole SOM..EOM packet, and the outgoing beat is registered.
//
// Ports
//   clk, reset_poweron             clock (rising edge), async active-low reset
//   req__arb__cp_*                 per-requester beat, packed (req i at slice i)
//   arb__req__cp_ready             per-requester ready
//   arb__noc__cp_*                 registered beat towards noc_cntl
//   noc__arb__cp_ready             NoC accepts the registered beat
//   arb__sys__busy                 high while a packet holds the lock
//   arb__sys__owner                locked requester, or last grant when idle
//   arb__sys__proto_err            sticky cntl-sequence violation flag
//   arb__sys__pkt_cnt              completed packets, wraps at 16 bits
// ----------------------------------------------------------------------------
module mgr_noc_cp_arb #(
    parameter int NUM_REQ  = 2,
    parameter int REQ_ID_W = 1,
    parameter int DATA_W   = 64,
    parameter int TYPE_W   = 2,
    parameter int LANE_W   = 5,
    parameter int STRM_W   = 1,
    parameter int CNTL_W   = 2
) (
    input  logic                        clk,
    input  logic                        reset_poweron,
    input  logic [NUM_REQ-1:0]          req__arb__cp_valid,
    input  logic [NUM_REQ*CNTL_W-1:0]   req__arb__cp_cntl,
    input  logic [NUM_REQ*TYPE_W-1:0]   req__arb__cp_type,
    input  logic [NUM_REQ*DATA_W-1:0]   req__arb__cp_data,
    input  logic [NUM_REQ*LANE_W-1:0]   req__arb__cp_laneId,
    input  logic [NUM_REQ*STRM_W-1:0]   req__arb__cp_strmId,
    output logic [NUM_REQ-1:0]          arb__req__cp_ready,
    output logic                        arb__noc__cp_valid,
    output logic [CNTL_W-1:0]           arb__noc__cp_cntl,
    output logic [TYPE_W-1:0]           arb__noc__cp_type,
    output logic [DATA_W-1:0]           arb__noc__cp_data,
    output logic [LANE_W-1:0]           arb__noc__cp_laneId,
    output logic [STRM_W-1:0]           arb__noc__cp_strmId,
    input  logic                        noc__arb__cp_ready,
    output logic                        arb__sys__busy,
    output logic [REQ_ID_W-1:0]         arb__sys__owner,
    output logic                        arb__sys__proto_err,
    output logic [15:0]                 arb__sys__pkt_cnt
);

    localparam logic [CNTL_W-1:0] CNTL_SOM_EOM = CNTL_W'(0);
    localparam logic [CNTL_W-1:0] CNTL_SOM     = CNTL_W'(1);
    localparam logic [CNTL_W-1:0] CNTL_MOM     = CNTL_W'(2);
    localparam logic [CNTL_W-1:0] CNTL_EOM     = CNTL_W'(3);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t              r_state;
    logic [REQ_ID_W-1:0] r_lock_id;
    logic [REQ_ID_W-1:0] r_rr_ptr;
    logic [REQ_ID_W-1:0] r_owner;
    logic                r_proto_err;
    logic [15:0]         r_pkt_cnt;
    logic                r_out_valid;
    logic [CNTL_W-1:0]   r_out_cntl;
    logic [TYPE_W-1:0]   r_out_type;
    logic [DATA_W-1:0]   r_out_data;
    logic [LANE_W-1:0]   r_out_lane;
    logic [STRM_W-1:0]   r_out_strm;

    logic                w_grant_vld;
    logic [REQ_ID_W-1:0] w_grant_id;
    logic                w_can_load;
    logic                w_accept;
    logic [CNTL_W-1:0]   w_sel_cntl;

    function automatic logic [REQ_ID_W-1:0] f_next_id(input logic [REQ_ID_W-1:0] id);
        if (int'(id) == NUM_REQ - 1) return '0;
        return id + 1'b1;
    endfunction

    // Grant: the locked owner while a packet is open, otherwise the first
    // valid requester at or after the round-robin pointer.
    always_comb begin
        int                  v_idx;
        logic [REQ_ID_W-1:0] v_sel;
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        v_idx       = 0;
        v_sel       = '0;
        w_grant_vld = 1'b0;
        w_grant_id  = '0;
        if (r_state == ST_LOCKED) begin
            w_grant_vld = 1'b1;
            w_grant_id  = r_lock_id;
        end else begin
            // Walk the offsets downwards so the smallest offset is written last.
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                v_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
                v_sel = REQ_ID_W'(v_idx);
                if (req__arb__cp_valid[v_sel]) begin
                    w_grant_vld = 1'b1;
                    w_grant_id  = v_sel;
                end
            end
        end
    end

    // Reset is folded in so no requester sees ready while reset is held.
    assign w_can_load = reset_poweron & (~r_out_valid | noc__arb__cp_ready);
    assign w_accept   = w_grant_vld & req__arb__cp_valid[w_grant_id] & w_can_load;
    assign w_sel_cntl = req__arb__cp_cntl[int'(w_grant_id)*CNTL_W +: CNTL_W];

    always_comb begin
        arb__req__cp_ready = '0;
        if (w_can_load && w_grant_vld) arb__req__cp_ready[w_grant_id] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            r_state     <= ST_IDLE;
            r_lock_id   <= '0;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_proto_err <= 1'b0;
            r_pkt_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_out_cntl  <= '0;
            r_out_type  <= '0;
            r_out_data  <= '0;
            r_out_lane  <= '0;
            r_out_strm  <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_cntl  <= w_sel_cntl;
            r_out_type  <= req__arb__cp_type[int'(w_grant_id)*TYPE_W +: TYPE_W];
            r_out_data  <= req__arb__cp_data[int'(w_grant_id)*DATA_W +: DATA_W];
            r_out_lane  <= req__arb__cp_laneId[int'(w_grant_id)*LANE_W +: LANE_W];
            r_out_strm  <= req__arb__cp_strmId[int'(w_grant_id)*STRM_W +: STRM_W];
            r_owner     <= w_grant_id;
            if (r_state == ST_IDLE) begin
                if (w_sel_cntl == CNTL_SOM) begin
                    r_state   <= ST_LOCKED;
                    r_lock_id <= w_grant_id;
                end else begin
                    // A stray MOM/EOM is flagged but still closed as one packet.
                    r_pkt_cnt <= r_pkt_cnt + 16'd1;
                    r_rr_ptr  <= f_next_id(w_grant_id);
                    if (w_sel_cntl != CNTL_SOM_EOM) r_proto_err <= 1'b1;
                end
            end else begin
                case (w_sel_cntl)
                    CNTL_MOM: begin
                    end
                    CNTL_EOM: begin
                        r_state   <= ST_IDLE;
                        r_pkt_cnt <= r_pkt_cnt + 16'd1;
                        r_rr_ptr  <= f_next_id(r_lock_id);
                    end
                    // A new SOM inside an open packet keeps the lock.
                    default: r_proto_err <= 1'b1;
                endcase
            end
        end else if (noc__arb__cp_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign arb__noc__cp_valid  = r_out_valid;
    assign arb__noc__cp_cntl   = r_out_cntl;
    assign arb__noc__cp_type   = r_out_type;
    assign arb__noc__cp_data   = r_out_data;
    assign arb__noc__cp_laneId = r_out_lane;
    assign arb__noc__cp_strmId = r_out_strm;
    assign arb__sys__busy      = (r_state == ST_LOCKED);
    assign arb__sys__owner     = r_owner;
    assign arb__sys__proto_err = r_proto_err;
    assign arb__sys__pkt_cnt   = r_pkt_cnt;

endmodule
